string_accel_core: RTL and testbench

Parametrised string accelerator behind the Nios II Avalon register wrapper. Processes strings of up to MAX_LEN ASCII bytes, LANES bytes per clock, under a go/done handshake. Supported ops: compare, to-upper, to-lower and find-char. Supersedes the fixed 2-byte string block, adds lane-parallel processing, to-lower, find-char, early-exit compare and length-error reporting.

---
 rtl/string_accel_pkg.sv | 33 +++
 rtl/string_lane.sv | 37 +++
 rtl/string_accel_core.sv | 185 ++++++++++++++++++
 tb/tb_string_accel_core.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/string_accel_pkg.sv
//------------------------------------------------------------------------------
// string_accel_pkg
// Shared types and ASCII constants for the lane-parallel string accelerator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package string_accel_pkg;

  typedef enum logic [1:0] {
    OP_CMP     = 2'd0,
    OP_TOUPPER = 2'd1,
    OP_TOLOWER = 2'd2,
    OP_FIND    = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0]  CH_A_UP    = 8'd65;
  localparam logic [7:0]  CH_Z_UP    = 8'd90;
  localparam logic [7:0]  CH_A_LO    = 8'd97;
  localparam logic [7:0]  CH_Z_LO    = 8'd122;
  localparam logic [7:0]  CASE_DELTA = 8'd32;
  localparam logic [31:0] NOT_FOUND  = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/string_lane.sv
//------------------------------------------------------------------------------
// string_lane
// One byte lane: case conversion, compare and search-char match.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module string_lane
  import string_accel_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] search,
  input  op_t        op,
  input  logic       valid,
  output logic [7:0] conv,
  output logic       eq,
  output logic       match
);

  // Masked lanes emit zero and never report a mismatch.
  always_comb begin
    conv = a;
    if (op == OP_TOUPPER && a >= CH_A_LO && a <= CH_Z_LO)
      conv = a - CASE_DELTA;
    else if (op == OP_TOLOWER && a >= CH_A_UP && a <= CH_Z_UP)
      conv = a + CASE_DELTA;
    if (!valid)
      conv = 8'd0;
  end

  assign eq    = !valid || (a == b);
  assign match = valid && (a == search);

endmodule

`default_nettype wire

// File: rtl/string_accel_core.sv
//------------------------------------------------------------------------------
// string_accel_core
// Lane-parallel compare / to-upper / to-lower / find-char engine, go/done handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module string_accel_core
  import string_accel_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LANES   = 4,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [1:0]           op,
  input  logic [8*MAX_LEN-1:0] str_a,
  input  logic [8*MAX_LEN-1:0] str_b,
  input  logic [LEN_W-1:0]     len_a,
  input  logic [LEN_W-1:0]     len_b,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [8*MAX_LEN-1:0] result_str,
  output logic [31:0]          result_val
);

  state_t               r_state, w_state_next;
  op_t                  r_op;
  logic [8*MAX_LEN-1:0] r_str_a, r_str_b, r_result_str;
  logic [LEN_W-1:0]     r_len_a, r_len_b, r_beat;
  logic [31:0]          r_result_val;
  logic                 r_busy, r_done, r_err;

  logic [31:0]          w_base, w_first;
  logic                 w_last, w_any, w_len_err, w_len_ne, w_len_zero;
  logic [31:0]          w_idx      [LANES];
  logic [31:0]          w_sel      [LANES];
  logic [7:0]           w_a        [LANES];
  logic [7:0]           w_b        [LANES];
  logic [7:0]           w_conv     [LANES];
  logic [LANES-1:0]     w_in_range, w_valid, w_eq, w_match;

  assign w_base     = 32'(r_beat) * 32'(LANES);
  assign w_last     = (w_base + 32'(LANES)) >= 32'(r_len_a);
  assign w_len_err  = (32'(r_len_a) > 32'(MAX_LEN)) ||
                      (r_op == OP_CMP && 32'(r_len_b) > 32'(MAX_LEN));
  assign w_len_ne   = (r_op == OP_CMP) && (r_len_a != r_len_b);
  assign w_len_zero = (r_len_a == '0);

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_idx[l]      = w_base + 32'(l);
      assign w_in_range[l] = w_idx[l] < 32'(MAX_LEN);
      assign w_sel[l]      = w_in_range[l] ? w_idx[l] : 32'd0;
      assign w_valid[l]    = w_in_range[l] && (w_idx[l] < 32'(r_len_a));

      // Constant-index byte mux keeps the selects in range for any LANES/MAX_LEN pair.
      always_comb begin
        w_a[l] = 8'd0;
        w_b[l] = 8'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
          if (w_sel[l] == 32'(i)) begin
            w_a[l] = r_str_a[8*i +: 8];
            w_b[l] = r_str_b[8*i +: 8];
          end
        end
      end

      string_lane u_lane (
        .a      (w_a[l]),
        .b      (w_b[l]),
        .search (r_str_b[7:0]),
        .op     (r_op),
        .valid  (w_valid[l]),
        .conv   (w_conv[l]),
        .eq     (w_eq[l]),
        .match  (w_match[l])
      );
    end
  endgenerate

  always_comb begin
    w_any   = 1'b0;
    w_first = 32'd0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_match[l]) begin
        w_any   = 1'b1;
        w_first = 32'(l);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (go) w_state_next = ST_LOAD;
      ST_LOAD: begin
        if (w_len_err || w_len_ne || w_len_zero) w_state_next = ST_DONE;
        else                                     w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if ((r_op == OP_CMP && !(&w_eq)) || (r_op == OP_FIND && w_any) || w_last)
          w_state_next = ST_DONE;
      end
      ST_DONE: if (!go) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= OP_CMP;
      r_str_a      <= '0;
      r_str_b      <= '0;
      r_len_a      <= '0;
      r_len_b      <= '0;
      r_beat       <= '0;
      r_result_str <= '0;
      r_result_val <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_LOAD) || (w_state_next == ST_RUN);
      r_done <= (w_state_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_op    <= op_t'(op);
            r_str_a <= str_a;
            r_str_b <= str_b;
            r_len_a <= len_a;
            r_len_b <= len_b;
          end
        end
        ST_LOAD: begin
          r_result_str <= '0;
          r_beat       <= '0;
          r_err        <= w_len_err;
          if (w_len_err)
            r_result_val <= 32'd0;
          else if (w_len_ne)
            r_result_val <= 32'd0;
          else if (w_len_zero && r_op == OP_CMP)
            r_result_val <= 32'd1;
          else if (w_len_zero && r_op == OP_FIND)
            r_result_val <= NOT_FOUND;
        end
        ST_RUN: begin
          r_beat <= r_beat + {{(LEN_W-1){1'b0}}, 1'b1};
          for (int i = 0; i < MAX_LEN; i++)
            for (int l = 0; l < LANES; l++)
              if (w_in_range[l] && w_sel[l] == 32'(i))
                r_result_str[8*i +: 8] <= w_conv[l];
          if (r_op == OP_CMP) begin
            if (!(&w_eq))  r_result_val <= 32'd0;
            else if (w_last) r_result_val <= 32'd1;
          end else if (r_op == OP_FIND) begin
            if (w_any)       r_result_val <= w_base + w_first;
            else if (w_last) r_result_val <= NOT_FOUND;
          end
        end
        ST_DONE: if (!go) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign result_str = r_result_str;
  assign result_val = r_result_val;

endmodule

`default_nettype wire

// File: tb/tb_string_accel_core.sv
//------------------------------------------------------------------------------
// tb_string_accel_core
// Directed vector table plus hand sequences for reset-abort and go hold in DONE.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_string_accel_core;

  localparam int MAX_LEN = 16;
  localparam int LANES   = 4;
  localparam int LEN_W   = 5;

  localparam logic [1:0] T_CMP = 2'd0, T_UP = 2'd1, T_LO = 2'd2, T_FIND = 2'd3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 go = 1'b0;
  logic [1:0]           op = 2'd0;
  logic [8*MAX_LEN-1:0] str_a = '0, str_b = '0;
  logic [LEN_W-1:0]     len_a = '0, len_b = '0;
  logic                 busy, done, err;
  logic [8*MAX_LEN-1:0] result_str;
  logic [31:0]          result_val;

  string_accel_core #(.MAX_LEN(MAX_LEN), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .go(go), .op(op),
    .str_a(str_a), .str_b(str_b), .len_a(len_a), .len_b(len_b),
    .busy(busy), .done(done), .err(err),
    .result_str(result_str), .result_val(result_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [127:0] a, b;
    logic [4:0]   la, lb;
    logic [127:0] estr;
    logic [31:0]  eval;
    logic         eerr;
    int           elat;
    bit           cstr, cval;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0, n_total = 0;

  function automatic logic [127:0] mk(input string s);
    logic [127:0] r = '0;
    for (int i = 0; i < s.len() && i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic add(input logic [1:0] o, input string a, input string b,
                     input int la, input int lb, input string es, input logic [31:0] ev,
                     input logic ee, input int lat, input bit cs, input bit cv);
    vec_t v;
    v.op = o; v.a = mk(a); v.b = mk(b); v.la = 5'(la); v.lb = 5'(lb);
    v.estr = mk(es); v.eval = ev; v.eerr = ee; v.elat = lat; v.cstr = cs; v.cval = cv;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run(input vec_t v, input int idx, input int hold);
    int k;
    @(negedge clk);
    op = v.op; str_a = v.a; str_b = v.b; len_a = v.la; len_b = v.lb; go = 1'b1;
    @(posedge clk); #1;
    k = 0;
    chk($sformatf("v%0d busy_after_go", idx), 128'(busy), 128'(1));
    // Scramble inputs once latched; the core must keep working on the captured copy.
    str_a = ~v.a; str_b = ~v.b; len_a = 5'd2; len_b = 5'd9; op = ~v.op;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("v%0d latency", idx), 128'(k), 128'(v.elat));
    chk($sformatf("v%0d err", idx), 128'(err), 128'(v.eerr));
    if (v.cstr) chk($sformatf("v%0d result_str", idx), result_str, v.estr);
    if (v.cval) chk($sformatf("v%0d result_val", idx), 128'(result_val), 128'(v.eval));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d hold_done", idx), 128'({done, busy}), 128'(2'b10));
      if (v.cval) chk($sformatf("v%0d hold_val", idx), 128'(result_val), 128'(v.eval));
    end
    @(negedge clk); go = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d idle_flags", idx), 128'({done, err, busy}), 128'(3'b000));
    if (v.cval) chk($sformatf("v%0d val_held", idx), 128'(result_val), 128'(v.eval));
    if (v.cstr) chk($sformatf("v%0d str_held", idx), result_str, v.estr);
  endtask

  initial begin
    //   op      str_a               str_b       la  lb  exp_str             exp_val        err lat cs cv
    add(T_UP,   "heLLo1{",          "",          7,  0, "HELLO1{",          32'd0,         0,  3, 1, 0);
    add(T_LO,   "AZ@[az",           "",          6,  0, "az@[az",           32'd0,         0,  3, 1, 0);
    add(T_CMP,  "abcdefgh",         "abcXefgh",  8,  8, "",                 32'd0,         0,  2, 0, 1);
    add(T_CMP,  "abcdefgh",         "abcdefgh",  8,  8, "",                 32'd1,         0,  3, 0, 1);
    add(T_CMP,  "abc",              "abcd",      3,  4, "",                 32'd0,         0,  1, 0, 1);
    add(T_CMP,  "",                 "",          0,  0, "",                 32'd1,         0,  1, 0, 1);
    add(T_FIND, "hello",            "l",         5,  0, "",                 32'd2,         0,  2, 0, 1);
    add(T_FIND, "hello",            "z",         5,  0, "",                 32'hFFFF_FFFF, 0,  3, 0, 1);
    add(T_UP,   "abc",              "",         17,  0, "",                 32'd0,         1,  1, 0, 0);
    add(T_FIND, "abcdefgh",         "f",         8,  0, "",                 32'd5,         0,  3, 0, 1);
    add(T_UP,   "abcdefgh",         "",          5,  0, "ABCDE",            32'd0,         0,  3, 1, 0);
    add(T_FIND, "abcdefgh",         "h",         7,  0, "",                 32'hFFFF_FFFF, 0,  3, 0, 1);
    add(T_CMP,  "abc",              "abc",       3, 20, "",                 32'd0,         1,  1, 0, 0);
    add(T_UP,   "abcdefghijklmnop", "",         16,  0, "ABCDEFGHIJKLMNOP", 32'd0,         0,  5, 1, 0);
    add(T_CMP,  "abcdZ",            "abcdY",     4,  4, "",                 32'd1,         0,  2, 0, 1);
    add(T_UP,   "",                 "",          0,  0, "",                 32'd0,         0,  1, 1, 0);
    add(T_FIND, "xaxa",             "a",         4,  0, "",                 32'd1,         0,  2, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 128'({busy, done, err}), 128'(3'b000));
    chk("reset_str", result_str, '0);
    chk("reset_val", 128'(result_val), 128'(0));
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) run(vecs[i], i, (i == 3) ? 5 : 0);

    // Abort a long to-upper mid-RUN; result_val is nonzero from the last FIND.
    @(negedge clk);
    op = T_UP; str_a = mk("abcdefghijklmnop"); len_a = 5'd16; go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_run_busy", 128'({busy, done}), 128'(2'b10));
    @(negedge clk); reset = 1'b1; go = 1'b0;
    @(posedge clk); #1;
    chk("abort_flags", 128'({busy, done, err}), 128'(3'b000));
    chk("abort_str", result_str, '0);
    chk("abort_val", 128'(result_val), 128'(0));
    @(negedge clk); reset = 1'b0;
    run(vecs[1], 99, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
